// File: rtl/bram.sv
// bmain block-RAM target: wrapping read bursts and strobed write bursts over one synchronous-read array.
// Build option: define BRAM_WRITE_EN to build the write path; without it the array is a ROM and writes report an error.
module bram #(
    parameter int DEPTH_LOG2 = 14,
    parameter int BURST_LOG2 = 2
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        bmain_cvalid_bram,
    output logic        bram_cready,
    input  logic        bmain_cmd,
    input  logic [25:0] bmain_addr,
    input  logic        bmain_wvalid_bram,
    output logic        bram_wready,
    input  logic [31:0] bmain_wdata,
    input  logic [3:0]  bmain_wstrb,
    input  logic        bmain_wlast,
    output logic        bram_rvalid,
    input  logic        bmain_rready_bram,
    output logic        bram_rlast,
    output logic [31:0] bram_rdata,
    output logic        bram_error,
    input  logic        bmain_eack_bram
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int BASE_W = DEPTH_LOG2 - BURST_LOG2;
    localparam logic [BURST_LOG2-1:0] LAST_BEAT = '1;

    typedef enum logic [2:0] {IDLE, READ, WRITE, WDRAIN, ERR} state_t;

    state_t                 state_reg, state_next;
    logic [BASE_W-1:0]      base_reg, base_next;
    logic [BURST_LOG2-1:0]  start_reg, start_next;
    logic [BURST_LOG2-1:0]  cnt_reg, cnt_next;
    logic                   rvalid_reg;
    logic                   rlast_reg;
    logic [31:0]            rdata_reg;
    logic                   issue;
    logic                   oor;
    logic [DEPTH_LOG2-1:0]  idx;

`ifdef BRAM_WRITE_EN
    logic                   werr_reg, werr_next;
    logic                   wr_beat;
    logic [31:0]            mem [DEPTH];
`else
    // ROM contents are supplied with the bitstream image; zero otherwise.
    logic [31:0]            mem [DEPTH] = '{default: '0};
    logic                   unused_wr;
    assign unused_wr = ^{bmain_wdata, bmain_wstrb, bmain_wlast};
`endif

    assign oor = |bmain_addr[25:DEPTH_LOG2];
    // Beat index wraps inside the aligned burst.
    assign idx = {base_reg, start_reg + cnt_reg};

    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        start_next  = start_reg;
        cnt_next    = cnt_reg;
        bram_cready = 1'b0;
        bram_wready = 1'b0;
        issue       = 1'b0;
`ifdef BRAM_WRITE_EN
        werr_next   = werr_reg;
        wr_beat     = 1'b0;
`endif
        case (state_reg)
            IDLE: bram_cready = 1'b1;
            READ: begin
                if (!rvalid_reg || bmain_rready_bram) begin
                    issue    = 1'b1;
                    cnt_next = cnt_reg + BURST_LOG2'(1);
                    if (cnt_reg == LAST_BEAT) begin
                        bram_cready = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
`ifdef BRAM_WRITE_EN
            WRITE: begin
                bram_wready = 1'b1;
                if (bmain_wvalid_bram) begin
                    wr_beat  = 1'b1;
                    cnt_next = cnt_reg + BURST_LOG2'(1);
                    if (bmain_wlast != (cnt_reg == LAST_BEAT))
                        werr_next = 1'b1;
                    if (cnt_reg == LAST_BEAT)
                        state_next = werr_next ? ERR : IDLE;
                end
            end
`endif
            WDRAIN: begin
                bram_wready = 1'b1;
                if (bmain_wvalid_bram) begin
                    cnt_next = cnt_reg + BURST_LOG2'(1);
                    if (cnt_reg == LAST_BEAT)
                        state_next = ERR;
                end
            end
            ERR: begin
                if (bmain_eack_bram)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (!reset_n) begin
            bram_cready = 1'b0;
            bram_wready = 1'b0;
            issue       = 1'b0;
`ifdef BRAM_WRITE_EN
            wr_beat     = 1'b0;
`endif
        end

        // A command may also be taken on the last read issue, so bursts stream back to back.
        if (bram_cready && bmain_cvalid_bram) begin
            base_next  = bmain_addr[DEPTH_LOG2-1:BURST_LOG2];
            start_next = bmain_addr[BURST_LOG2-1:0];
            cnt_next   = '0;
`ifdef BRAM_WRITE_EN
            werr_next  = 1'b0;
            if (oor)
                state_next = bmain_cmd ? WDRAIN : ERR;
            else
                state_next = bmain_cmd ? WRITE : READ;
`else
            if (bmain_cmd)
                state_next = WDRAIN;
            else
                state_next = oor ? ERR : READ;
`endif
        end
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            start_reg  <= '0;
            cnt_reg    <= '0;
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
`ifdef BRAM_WRITE_EN
            werr_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            start_reg <= start_next;
            cnt_reg   <= cnt_next;
`ifdef BRAM_WRITE_EN
            werr_reg  <= werr_next;
`endif
            if (issue) begin
                rvalid_reg <= 1'b1;
                rlast_reg  <= (cnt_reg == LAST_BEAT);
            end else if (bram_rvalid && bmain_rready_bram) begin
                rvalid_reg <= 1'b0;
                rlast_reg  <= 1'b0;
            end
        end
    end

    // Read port doubles as the output register: it only loads on issue, so a stall holds rdata.
    always_ff @(posedge clk_core) begin
        if (!reset_n)
            rdata_reg <= '0;
        else if (issue)
            rdata_reg <= mem[idx];
    end

`ifdef BRAM_WRITE_EN
    always_ff @(posedge clk_core) begin
        if (wr_beat && reset_n) begin
            for (int b = 0; b < 4; b++) begin
                if (bmain_wstrb[b])
                    mem[idx][b*8 +: 8] <= bmain_wdata[b*8 +: 8];
            end
        end
    end
`endif

    // A beat left over when an error is entered is held back until the error is acknowledged.
    assign bram_rvalid = rvalid_reg && (state_reg != ERR);
    assign bram_rlast  = rlast_reg && (state_reg != ERR);
    assign bram_rdata  = rdata_reg;
    assign bram_error  = (state_reg == ERR);

endmodule

// File: tb/tb_bram.sv
// Scoreboard bench for bram: stimulus pushes expected read beats, a negedge monitor pops and compares them.
module tb_bram;

    logic        clk_core = 1'b0;
    logic        reset_n = 1'b0;
    logic        bmain_cvalid_bram = 1'b0;
    logic        bram_cready;
    logic        bmain_cmd = 1'b0;
    logic [25:0] bmain_addr = '0;
    logic        bmain_wvalid_bram = 1'b0;
    logic        bram_wready;
    logic [31:0] bmain_wdata = '0;
    logic [3:0]  bmain_wstrb = '0;
    logic        bmain_wlast = 1'b0;
    logic        bram_rvalid;
    logic        bmain_rready_bram = 1'b1;
    logic        bram_rlast;
    logic [31:0] bram_rdata;
    logic        bram_error;
    logic        bmain_eack_bram = 1'b0;

    bram dut (
        .clk_core          (clk_core),
        .reset_n           (reset_n),
        .bmain_cvalid_bram (bmain_cvalid_bram),
        .bram_cready       (bram_cready),
        .bmain_cmd         (bmain_cmd),
        .bmain_addr        (bmain_addr),
        .bmain_wvalid_bram (bmain_wvalid_bram),
        .bram_wready       (bram_wready),
        .bmain_wdata       (bmain_wdata),
        .bmain_wstrb       (bmain_wstrb),
        .bmain_wlast       (bmain_wlast),
        .bram_rvalid       (bram_rvalid),
        .bmain_rready_bram (bmain_rready_bram),
        .bram_rlast        (bram_rlast),
        .bram_rdata        (bram_rdata),
        .bram_error        (bram_error),
        .bmain_eack_bram   (bmain_eack_bram)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ed[4];
    logic [31:0] wd[4];

    always @(posedge clk_core) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Old contents of words 0x20..0x23 and their value after the 0101-strobed write of 0xAABBCCDD.
    function automatic logic [31:0] old20(input int j);
        return 32'h1122_3340 + (32'(j) << 8);
    endfunction

    function automatic logic [31:0] new20(input int j);
`ifdef BRAM_WRITE_EN
        return (old20(j) & 32'hFF00_FF00) | 32'h00BB_00DD;
`else
        return old20(j);
`endif
    endfunction

    task automatic send_cmd(input logic cmd, input logic [25:0] addr, output int t_acc);
        bmain_cvalid_bram = 1'b1;
        bmain_cmd         = cmd;
        bmain_addr        = addr;
        t_acc             = -1;
        for (int i = 0; i < 50 && t_acc < 0; i++) begin
            @(negedge clk_core);
            if (bram_cready) t_acc = cyc;
            tick();
        end
        bmain_cvalid_bram = 1'b0;
        $display("command %s addr %h accepted in cycle %0d", cmd ? "write" : "read", addr, t_acc);
        check1("cmd_accept", t_acc >= 0, 1'b1);
    endtask

    task automatic push_beats(input int t0, input int gap, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = ed[k];
            b.last = (k == 3);
            b.cyc  = t0 + 2 + k + ((k > 0) ? gap : 0);
            sb.push_back(b);
        end
    endtask

    task automatic write_burst(input logic [25:0] addr, input logic [3:0] strb, input int last_k);
        int   t;
        int   t_first;
        logic ok;
        send_cmd(1'b1, addr, t);
        t_first = -1;
        for (int k = 0; k < 4; k++) begin
            bmain_wvalid_bram = 1'b1;
            bmain_wdata       = wd[k];
            bmain_wstrb       = strb;
            bmain_wlast       = (k == last_k);
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk_core);
                ok = bram_wready;
                if (ok && k == 0) t_first = cyc;
                tick();
            end
            check1("wbeat_accept", ok, 1'b1);
        end
        bmain_wvalid_bram = 1'b0;
        bmain_wlast       = 1'b0;
        $display("write burst addr %h strb %b wlast on beat %0d", addr, strb, last_k + 1);
        check("wready_rise", t_first, t + 1);
    endtask

    task automatic expect_error(input string name);
        @(negedge clk_core);
        check1({name, "_error_rise"}, bram_error, 1'b1);
        check1({name, "_quiet_in_err"}, bram_cready | bram_wready | bram_rvalid, 1'b0);
        bmain_eack_bram = 1'b1;
        tick();
        bmain_eack_bram = 1'b0;
        @(negedge clk_core);
        check1({name, "_error_fall"}, bram_error, 1'b0);
        check1({name, "_cready_after_eack"}, bram_cready, 1'b1);
        $display("error %s acknowledged", name);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        check("sb_drain", sb.size(), 0);
    endtask

    // Monitor: every accepted read beat is popped from the scoreboard; stalled beats must hold.
    initial begin : monitor
        beat_t       e;
        logic        stall_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk_core);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!bram_rvalid || bram_rdata !== prev_data || bram_rlast !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: got rvalid=%b rdata=%h rlast=%b, expected rvalid=1 rdata=%h rlast=%b",
                                 bram_rvalid, bram_rdata, bram_rlast, prev_data, prev_last);
                    end
                end
                if (bram_rvalid && bmain_rready_bram) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got rdata=%h in cycle %0d, expected no beat", bram_rdata, cyc);
                    end else begin
                        e = sb.pop_front();
                        $display("read beat cycle %0d data %h last %b", cyc, bram_rdata, bram_rlast);
                        if (bram_rdata !== e.data || bram_rlast !== e.last || (e.cyc >= 0 && cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL read_beat: got data=%h last=%b cycle=%0d, expected data=%h last=%b cycle=%0d",
                                     bram_rdata, bram_rlast, cyc, e.data, e.last, e.cyc);
                        end
                    end
                end
                stall_prev = bram_rvalid && !bmain_rready_bram;
                prev_data  = bram_rdata;
                prev_last  = bram_rlast;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t1;
        int t2;
        reset_n = 1'b0;
        tick();
`ifndef BRAM_WRITE_EN
        for (int j = 0; j < 4; j++) begin
            dut.mem[16 + j] = 32'h10 + 32'(j);
            dut.mem[32 + j] = old20(j);
        end
`endif
        tick();
        tick();
        @(negedge clk_core);
        check1("reset_cready", bram_cready, 1'b0);
        check1("reset_rvalid", bram_rvalid, 1'b0);
        check1("reset_rlast", bram_rlast, 1'b0);
        check1("reset_wready", bram_wready, 1'b0);
        check1("reset_error", bram_error, 1'b0);
        check("reset_rdata", bram_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        @(negedge clk_core);
        check1("cready_after_release", bram_cready, 1'b1);
        tick();

`ifdef BRAM_WRITE_EN
        for (int j = 0; j < 4; j++) wd[j] = 32'h10 + 32'(j);
        write_burst(26'h10, 4'hF, 3);
        for (int j = 0; j < 4; j++) wd[j] = old20(j);
        write_burst(26'h20, 4'hF, 3);
`endif

        // Aligned read followed back to back by a wrapping read.
        ed[0] = 32'h10; ed[1] = 32'h11; ed[2] = 32'h12; ed[3] = 32'h13;
        send_cmd(1'b0, 26'h10, t1);
        push_beats(t1, 0, 4);
        ed[0] = 32'h12; ed[1] = 32'h13; ed[2] = 32'h10; ed[3] = 32'h11;
        send_cmd(1'b0, 26'h12, t2);
        check("b2b_accept_cycle", t2, t1 + 4);
        push_beats(t1 + 4, 0, 4);
        drain();

        // rready pattern 1,0,0,1 on the first four beat cycles.
        ed[0] = 32'h10; ed[1] = 32'h11; ed[2] = 32'h12; ed[3] = 32'h13;
        send_cmd(1'b0, 26'h10, t1);
        push_beats(t1, 2, 4);
        tick();
        tick();
        bmain_rready_bram = 1'b0;
        tick();
        tick();
        bmain_rready_bram = 1'b1;
        drain();

        // Strobed write of bytes 0 and 2, then read back.
        for (int j = 0; j < 4; j++) wd[j] = 32'hAABB_CCDD;
        write_burst(26'h20, 4'b0101, 3);
`ifndef BRAM_WRITE_EN
        expect_error("rom_write");
`endif
        for (int j = 0; j < 4; j++) ed[j] = new20(j);
        send_cmd(1'b0, 26'h20, t1);
        push_beats(t1, 0, 4);
        drain();

        // Out-of-range read and write (byte address bit 27).
        send_cmd(1'b0, 26'h200_0010, t1);
        expect_error("oor_read");
        for (int j = 0; j < 4; j++) wd[j] = 32'hDEAD_0000 + 32'(j);
        write_burst(26'h200_0020, 4'hF, 3);
        expect_error("oor_write");

        // Early wlast on beat 2: all beats accepted, error afterwards.
        for (int j = 0; j < 4; j++) wd[j] = 32'hC0DE_0000 + 32'(j);
        write_burst(26'h30, 4'hF, 1);
        expect_error("early_wlast");
`ifdef BRAM_WRITE_EN
        for (int j = 0; j < 4; j++) ed[j] = wd[j];
        send_cmd(1'b0, 26'h30, t1);
        push_beats(t1, 0, 4);
        drain();
`endif

        // Reset while the second beat is on the bus.
        ed[0] = 32'h10; ed[1] = 32'h11; ed[2] = 32'h12; ed[3] = 32'h13;
        send_cmd(1'b0, 26'h10, t1);
        push_beats(t1, 0, 1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk_core);
        check1("rvalid_after_reset", bram_rvalid, 1'b0);
        check1("cready_in_reset", bram_cready, 1'b0);
        tick();
        reset_n = 1'b1;
        @(negedge clk_core);
        check1("cready_after_mid_reset", bram_cready, 1'b1);
        tick();

        // Storage survives the reset; also shows the out-of-range write left 0x20 alone.
        for (int j = 0; j < 4; j++) ed[j] = new20(j);
        send_cmd(1'b0, 26'h20, t1);
        push_beats(t1, 0, 4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
